// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_if
// Brief    : Nibble stream and load-start signals between the program source
//            and the instruction-store loader.
// Revision : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
    parameter int NIB_W = 4
);
    logic             start;
    logic [NIB_W-1:0] nib_data;
    logic             nib_valid;
    logic             nib_ready;

    modport master (
        output start,
        output nib_data,
        output nib_valid,
        input  nib_ready
    );

    modport slave (
        input  start,
        input  nib_data,
        input  nib_valid,
        output nib_ready
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Loadable DEPTH x INSTR_W instruction store fed by a nibble stream.
//            Optional trailing XOR checksum nibble: PROG_LOADER_CKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int INSTR_W = 12,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int NIB_W   = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    prog_loader_if.slave            bus,
    input  wire logic [ADDR_W-1:0]  rd_addr,
    output logic      [INSTR_W-1:0] rd_data,
    output logic                    run,
    output logic                    busy,
    output logic                    err,
    output logic      [ADDR_W:0]    words_loaded
);

`ifdef PROG_LOADER_CKSUM_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_CHECK = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_phase;
    logic [ADDR_W-1:0]  r_waddr;
    logic [ADDR_W:0]    r_words;
    logic [NIB_W-1:0]   r_n0;
    logic [NIB_W-1:0]   r_n1;
    logic [INSTR_W-1:0] r_store [DEPTH];

    logic w_xfer;
    logic w_load_start;
    logic w_last_word;

    assign w_xfer       = bus.nib_valid && bus.nib_ready;
    assign w_load_start = bus.start && ((r_state == S_IDLE) || (r_state == S_RUN));
    assign w_last_word  = w_xfer && (r_state == S_LOAD) && (r_phase == 2'd2)
                          && (r_waddr == ADDR_W'(DEPTH - 1));

    // Handshake and status decode straight from the state register.
`ifdef PROG_LOADER_CKSUM_EN
    assign bus.nib_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign busy          = (r_state == S_LOAD) || (r_state == S_CHECK);
`else
    assign bus.nib_ready = (r_state == S_LOAD);
    assign busy          = (r_state == S_LOAD);
`endif
    assign run          = (r_state == S_RUN);
    assign words_loaded = r_words;
    assign rd_data      = r_store[rd_addr];

`ifdef PROG_LOADER_CKSUM_EN
    logic [NIB_W-1:0] r_cksum;
    logic             r_err;
    logic             w_cks_ok;

    assign w_cks_ok = (bus.nib_data == r_cksum);
    assign err      = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cksum <= '0;
            r_err   <= 1'b0;
        end else if (w_load_start) begin
            r_cksum <= '0;
            r_err   <= 1'b0;
        end else if (w_xfer && (r_state == S_LOAD)) begin
            r_cksum <= r_cksum ^ bus.nib_data;
        end else if (w_xfer && (r_state == S_CHECK) && !w_cks_ok) begin
            r_err   <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (w_last_word) begin
`ifdef PROG_LOADER_CKSUM_EN
                    w_state_nxt = S_CHECK;
`else
                    w_state_nxt = S_RUN;
`endif
                end
            end
            S_RUN:  if (bus.start) w_state_nxt = S_LOAD;
`ifdef PROG_LOADER_CKSUM_EN
            S_CHECK: if (w_xfer) w_state_nxt = w_cks_ok ? S_RUN : S_IDLE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A reload from RUN keeps old words; each is overwritten as it arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 2'd0;
            r_waddr <= '0;
            r_words <= '0;
            r_n0    <= '0;
            r_n1    <= '0;
            for (int i = 0; i < DEPTH; i++) r_store[i] <= '0;
        end else if (w_load_start) begin
            r_phase <= 2'd0;
            r_waddr <= '0;
            r_words <= '0;
        end else if (w_xfer && (r_state == S_LOAD)) begin
            unique case (r_phase)
                2'd0: begin
                    r_n0    <= bus.nib_data;
                    r_phase <= 2'd1;
                end
                2'd1: begin
                    r_n1    <= bus.nib_data;
                    r_phase <= 2'd2;
                end
                default: begin
                    r_store[r_waddr] <= {r_n0, r_n1, bus.nib_data};
                    r_waddr          <= r_waddr + ADDR_W'(1);
                    r_words          <= r_words + (ADDR_W + 1)'(1);
                    r_phase          <= 2'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Randomized self-checking bench for prog_loader against a word-level
//            store model. Honours PROG_LOADER_CKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
    localparam int INSTR_W = 12;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int NIB_W   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if #(.NIB_W(NIB_W)) bus ();

    logic [ADDR_W-1:0]  rd_addr;
    logic [INSTR_W-1:0] rd_data;
    logic               run;
    logic               busy;
    logic               err;
    logic [ADDR_W:0]    words_loaded;

    prog_loader #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .NIB_W   (NIB_W)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .run          (run),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [INSTR_W-1:0] m_store [DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_store(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = ADDR_W'(a);
            #1;
            check_eq(tag, 32'(rd_data), 32'(m_store[a]));
        end
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic send_nib(input logic [NIB_W-1:0] n, input bit gap);
        int t = 0;
        if (gap) begin
            bus.nib_valid = 1'b0;
            @(negedge clk);
        end
        bus.nib_data  = n;
        bus.nib_valid = 1'b1;
        while (!bus.nib_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check_eq("nib_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.nib_valid = 1'b0;
    endtask

    task automatic do_load(input logic [INSTR_W-1:0] w [DEPTH], input int gapmode,
                           input int stop_after, input int restart_at, input bit bad_cks);
        logic [NIB_W-1:0] nib;
        logic [NIB_W-1:0] cks;
        bit               gap;
        cks = '0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_run", 32'(run), 32'd0);
        check_eq("start_words", 32'(words_loaded), 32'd0);
        rd_addr = '0;
        #1;
        check_eq("no_clear_on_start", 32'(rd_data), 32'(m_store[0]));
        for (int i = 0; i < 3 * DEPTH; i++) begin
            if (i == stop_after) return;
            if (i == restart_at) begin
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            nib = NIB_W'(w[i / 3] >> (NIB_W * (2 - (i % 3))));
            cks ^= nib;
            gap = (gapmode == 1) ? (i % 2 == 1) :
                  (gapmode == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
            send_nib(nib, gap);
            if (i % 3 == 2) begin
                m_store[i / 3] = w[i / 3];
                rd_addr = ADDR_W'(i / 3);
                #1;
                check_eq("word_count", 32'(words_loaded), 32'(i / 3 + 1));
                check_eq("word_write", 32'(rd_data), 32'(w[i / 3]));
`ifdef PROG_LOADER_CKSUM_EN
                check_eq("run_during_load", 32'(run), 32'd0);
                check_eq("busy_during_load", 32'(busy), 32'd1);
`else
                check_eq("run_during_load", 32'(run), (i == 3 * DEPTH - 1) ? 32'd1 : 32'd0);
                check_eq("busy_during_load", 32'(busy), (i == 3 * DEPTH - 1) ? 32'd0 : 32'd1);
`endif
            end
        end
        @(negedge clk);
`ifdef PROG_LOADER_CKSUM_EN
        send_nib(bad_cks ? (cks ^ NIB_W'(1)) : cks, 1'b0);
        check_eq("cks_run", 32'(run), bad_cks ? 32'd0 : 32'd1);
        check_eq("cks_err", 32'(err), bad_cks ? 32'd1 : 32'd0);
        check_eq("cks_busy", 32'(busy), 32'd0);
        check_eq("cks_ready", 32'(bus.nib_ready), 32'd0);
`else
        check_eq("err_tied", 32'(err), 32'd0 | 32'(bad_cks & 1'b0));
`endif
        check_eq("final_words", 32'(words_loaded), 32'(DEPTH));
        check_store("final_store");
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_run"}, 32'(run), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_ready"}, 32'(bus.nib_ready), 32'd0);
        check_eq({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    logic [INSTR_W-1:0] prog1 [DEPTH];
    logic [INSTR_W-1:0] progx [DEPTH];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.nib_valid = 1'b0;
        bus.nib_data  = '0;
        rd_addr       = '0;
        for (int a = 0; a < DEPTH; a++) m_store[a] = '0;
        prog1 = '{12'h240, 12'h480, 12'h6C0, 12'h900, 12'h1F9, 12'h000, 12'h000, 12'h000};

        repeat (2) @(negedge clk);
        check_reset_state("reset");
        check_store("reset_store");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("idle");

        // Ready is low in IDLE: offered nibbles must be dropped
        bus.nib_valid = 1'b1;
        bus.nib_data  = 4'hA;
        repeat (3) @(negedge clk);
        bus.nib_valid = 1'b0;
        check_reset_state("idle_valid");

        do_load(prog1, 0, -1, -1, 1'b0);
        rd_addr = ADDR_W'(4);
        #1;
        check_eq("prog1_addr4", 32'(rd_data), 32'h1F9);
        @(negedge clk);

        // In RUN, offered nibbles are ignored too
        bus.nib_valid = 1'b1;
        bus.nib_data  = 4'h5;
        repeat (3) @(negedge clk);
        bus.nib_valid = 1'b0;
        check_eq("run_valid_run", 32'(run), 32'd1);
        check_eq("run_valid_words", 32'(words_loaded), 32'(DEPTH));
        check_store("run_valid_store");

        do_load(prog1, 1, -1, -1, 1'b0);

        for (int a = 0; a < DEPTH; a++) progx[a] = 12'h0A5;
        do_load(progx, 0, -1, -1, 1'b0);

        for (int a = 0; a < DEPTH; a++) progx[a] = INSTR_W'($urandom);
        do_load(progx, 2, 10, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int a = 0; a < DEPTH; a++) m_store[a] = '0;
        check_reset_state("midload_reset");
        check_store("midload_reset_store");
        rst_n = 1'b1;
        @(negedge clk);
        do_load(progx, 0, -1, -1, 1'b0);

        for (int a = 0; a < DEPTH; a++) progx[a] = INSTR_W'($urandom);
        do_load(progx, 0, -1, 5, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < DEPTH; a++) progx[a] = INSTR_W'($urandom);
            do_load(progx, 2, -1, -1, 1'b0);
        end

`ifdef PROG_LOADER_CKSUM_EN
        do_load(prog1, 0, -1, -1, 1'b1);
        check_eq("bad_cks_idle_ready", 32'(bus.nib_ready), 32'd0);
        do_load(prog1, 2, -1, -1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
